vfifo_wr_arb: RTL

Round-robin write arbiter that shares the single write port of one vector FIFO among NREQ SIMD producers. Each producer holds a grant for a burst of up to MAX_BURST beats, or until it signals last, so one producer's vector packet lands contiguously in the FIFO. The block sits between the lane producers and the FIFO's i_write/i_data/o_fifo_full port; the read side of the FIFO is untouched.

---
 rtl/vfifo_wr_arb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vfifo_wr_arb.sv
// vfifo_wr_arb: round-robin arbiter sharing one vector FIFO write port among
// NREQ producers. A grant lasts until the producer's last beat, MAX_BURST
// accepted beats, or the producer dropping valid.
module vfifo_wr_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 248,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ-1:0]                  req_last,
  input  logic [NREQ*WIDTH-1:0]            req_data,
  output logic [NREQ-1:0]                  req_ready,
  input  logic                             fifo_full,
  output logic                             fifo_write,
  output logic [WIDTH-1:0]                 fifo_data,
  output logic [NREQ-1:0]                  o_grant,
  output logic                             o_busy,
  output logic [$clog2(MAX_BURST+1)-1:0]   o_beat_cnt
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;

  logic [WIDTH-1:0]   data_arr [NREQ];
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_found;
  logic               accept_c;
  logic               burst_end_c;
  logic [CNT_W-1:0]   cnt_inc;

  // Split the flat producer data bus into per-producer words
  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign data_arr[k] = req_data[k*WIDTH +: WIDTH];
  end

  // Encode the one-hot registered grant into an index
  always_comb begin
    gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q[k]) gidx = IDX_W'(k);
    end
  end

  // Round-robin search: first valid requester after last_winner, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_winner_q;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((32'(last_winner_q) + 32'(i)) % 32'(NREQ));
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Write-port handshake; only the granted producer can see ready
  always_comb begin
    req_ready  = grant_q & {NREQ{~fifo_full}};
    accept_c   = busy_q & req_valid[gidx] & ~fifo_full;
    fifo_write = accept_c;
    fifo_data  = busy_q ? data_arr[gidx] : '0;
  end

  // Burst end: last beat, beat budget exhausted, or producer released grant
  always_comb begin
    cnt_inc     = cnt_q + CNT_W'(1);
    burst_end_c = 1'b0;
    if (accept_c && req_last[gidx])                  burst_end_c = 1'b1;
    else if (accept_c && cnt_inc == CNT_W'(MAX_BURST)) burst_end_c = 1'b1;
    else if (!req_valid[gidx])                       burst_end_c = 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    last_winner_d = last_winner_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BURST;
          grant_d = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (burst_end_c) begin
          state_d       = IDLE;
          grant_d       = '0;
          busy_d        = 1'b0;
          cnt_d         = '0;
          last_winner_d = gidx;
        end else if (accept_c) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; requester 0 gets top priority after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      last_winner_q <= IDX_W'(NREQ - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_beat_cnt = cnt_q;

endmodule
